// File: rtl/nim_undo_stack_if.sv
// Move/undo/restore bundle between the Nim move path, the heap file and the undo stack.
// Parameters must match the attached nim_undo_stack instance.
interface nim_undo_stack_if #(
  parameter int unsigned HEAPS   = 4,
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned DEPTH   = 8
);
  localparam int unsigned IW = (HEAPS > 1) ? $clog2(HEAPS) : 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic               move_valid;
  logic [IW-1:0]      move_heap;
  logic [COUNT_W-1:0] move_taken;
  logic               undo_req;
  logic [IW-1:0]      heap_sel;
  logic [COUNT_W-1:0] heap_value_i;
  logic               restore_valid;
  logic [IW-1:0]      restore_heap;
  logic [COUNT_W-1:0] restore_value;
  logic               restore_sat;
  logic               busy;
  logic               undo_empty;
  logic               move_drop;
  logic [PW:0]        depth_count;

  modport master (
    output move_valid, move_heap, move_taken, undo_req, heap_value_i,
    input  heap_sel, restore_valid, restore_heap, restore_value, restore_sat,
    input  busy, undo_empty, move_drop, depth_count
  );

  modport slave (
    input  move_valid, move_heap, move_taken, undo_req, heap_value_i,
    output heap_sel, restore_valid, restore_heap, restore_value, restore_sat,
    output busy, undo_empty, move_drop, depth_count
  );
endinterface

// File: rtl/nim_undo_stack.sv
// Circular LIFO of committed Nim moves; an undo pops the latest move and adds its stones
// back to the heap, saturating at the heap count maximum.
module nim_undo_stack #(
  parameter int unsigned HEAPS   = 4,
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned DEPTH   = 8
) (
  input logic               clk,
  input logic               reset,
  nim_undo_stack_if.slave   bus
);
  localparam int unsigned IW   = (HEAPS > 1) ? $clog2(HEAPS) : 1;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PW + 1;
  localparam logic [PW-1:0]   LastPtr = PW'(DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StPop, StAdd, StDone} state_e;

  state_e             state_q;
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr;
  logic [CntW-1:0]    depth_q;
  logic [IW-1:0]      heap_mem  [DEPTH];
  logic [COUNT_W-1:0] taken_mem [DEPTH];
  logic [IW-1:0]      heap_sel_q;
  logic [COUNT_W-1:0] taken_q;
  logic               restore_valid_q;
  logic [IW-1:0]      restore_heap_q;
  logic [COUNT_W-1:0] restore_value_q;
  logic               restore_sat_q;
  logic               busy_q;
  logic               undo_empty_q;
  logic               move_drop_q;
  logic               push;
  logic [COUNT_W:0]   sum;

  assign push   = (state_q == StIdle) && bus.move_valid;
  assign rd_ptr = (wr_ptr_q == '0) ? LastPtr : wr_ptr_q - 1'b1;
  assign sum    = {1'b0, bus.heap_value_i} + {1'b0, taken_q};

  // History storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      heap_mem[wr_ptr_q]  <= bus.move_heap;
      taken_mem[wr_ptr_q] <= bus.move_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      depth_q         <= '0;
      heap_sel_q      <= '0;
      taken_q         <= '0;
      restore_valid_q <= 1'b0;
      restore_heap_q  <= '0;
      restore_value_q <= '0;
      restore_sat_q   <= 1'b0;
      busy_q          <= 1'b0;
      undo_empty_q    <= 1'b0;
      move_drop_q     <= 1'b0;
    end else begin
      undo_empty_q    <= 1'b0;
      move_drop_q     <= 1'b0;
      restore_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.move_valid) begin
            // A push beats a same-cycle undo; the requester re-issues it.
            wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            if (depth_q != FullCnt) begin
              depth_q <= depth_q + 1'b1;
            end
          end else if (bus.undo_req) begin
            if (depth_q == '0) begin
              undo_empty_q <= 1'b1;
            end else begin
              // Load the top entry now so heap_sel is valid throughout POP.
              heap_sel_q <= heap_mem[rd_ptr];
              taken_q    <= taken_mem[rd_ptr];
              busy_q     <= 1'b1;
              state_q    <= StPop;
            end
          end
        end
        StPop: begin
          move_drop_q <= bus.move_valid;
          wr_ptr_q    <= rd_ptr;
          depth_q     <= depth_q - 1'b1;
          state_q     <= StAdd;
        end
        StAdd: begin
          move_drop_q     <= bus.move_valid;
          restore_heap_q  <= heap_sel_q;
          restore_sat_q   <= sum[COUNT_W];
          restore_value_q <= sum[COUNT_W] ? '1 : sum[COUNT_W-1:0];
          restore_valid_q <= 1'b1;
          state_q         <= StDone;
        end
        StDone: begin
          move_drop_q <= bus.move_valid;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.heap_sel      = heap_sel_q;
  assign bus.restore_valid = restore_valid_q;
  assign bus.restore_heap  = restore_heap_q;
  assign bus.restore_value = restore_value_q;
  assign bus.restore_sat   = restore_sat_q;
  assign bus.busy          = busy_q;
  assign bus.undo_empty    = undo_empty_q;
  assign bus.move_drop     = move_drop_q;
  assign bus.depth_count   = depth_q;
endmodule

// File: tb/tb_nim_undo_stack.sv
// Directed bench for nim_undo_stack: a move-history model predicts restores, which are
// queued and compared when restore_valid appears.
module tb_nim_undo_stack;
  localparam int unsigned HEAPS   = 4;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned DEPTH   = 8;

  typedef struct packed {
    logic [1:0] heap;
    logic [3:0] taken;
  } mv_t;

  typedef struct packed {
    logic [1:0] heap;
    logic [3:0] value;
    logic       sat;
  } rs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] heaps [HEAPS];
  mv_t model [$];
  rs_t sb [$];
  int checks = 0;
  int errors = 0;

  nim_undo_stack_if #(.HEAPS(HEAPS), .COUNT_W(COUNT_W), .DEPTH(DEPTH)) bus ();

  nim_undo_stack #(.HEAPS(HEAPS), .COUNT_W(COUNT_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.heap_value_i = heaps[bus.heap_sel];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (bus.restore_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_restore", 32'(bus.restore_valid), 32'd0);
      end else begin
        rs_t e;
        e = sb.pop_front();
        check("restore_heap", 32'(bus.restore_heap), 32'(e.heap));
        check("restore_value", 32'(bus.restore_value), 32'(e.value));
        check("restore_sat", 32'(bus.restore_sat), 32'(e.sat));
      end
    end
  end

  task automatic do_push(input logic [1:0] h, input logic [3:0] t);
    mv_t m;
    m.heap  = h;
    m.taken = t;
    if (model.size() == DEPTH) void'(model.pop_front());
    model.push_back(m);
    bus.move_valid = 1'b1;
    bus.move_heap  = h;
    bus.move_taken = t;
    tick();
    bus.move_valid = 1'b0;
    check("push_depth", 32'(bus.depth_count), 32'(model.size()));
  endtask

  // Undo with the exact 4-cycle timeline; optionally offers a move during POP.
  task automatic do_undo(input bit drop);
    mv_t m;
    rs_t e;
    int s;
    bit empty_exp;
    empty_exp = (model.size() == 0);
    bus.undo_req = 1'b1;
    if (!empty_exp) begin
      m = model.pop_back();
      s = int'(heaps[m.heap]) + int'(m.taken);
      e.heap  = m.heap;
      e.sat   = (s > 15);
      e.value = e.sat ? 4'hf : 4'(s);
      sb.push_back(e);
    end
    tick();
    bus.undo_req = 1'b0;
    if (empty_exp) begin
      check("undo_empty_pulse", 32'(bus.undo_empty), 32'd1);
      check("empty_not_busy", 32'(bus.busy), 32'd0);
      tick();
      check("undo_empty_clear", 32'(bus.undo_empty), 32'd0);
      return;
    end
    check("pop_busy", 32'(bus.busy), 32'd1);
    check("pop_heap_sel", 32'(bus.heap_sel), 32'(m.heap));
    if (drop) begin
      bus.move_valid = 1'b1;
      bus.move_heap  = 2'd0;
      bus.move_taken = 4'd5;
    end
    tick();
    bus.move_valid = 1'b0;
    check("add_depth", 32'(bus.depth_count), 32'(model.size()));
    check("add_heap_sel", 32'(bus.heap_sel), 32'(m.heap));
    check("add_no_restore", 32'(bus.restore_valid), 32'd0);
    if (drop) check("move_drop_pulse", 32'(bus.move_drop), 32'd1);
    tick();
    check("done_restore_valid", 32'(bus.restore_valid), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd1);
    if (drop) begin
      check("move_drop_clear", 32'(bus.move_drop), 32'd0);
      check("drop_depth", 32'(bus.depth_count), 32'(model.size()));
    end
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_restore_valid", 32'(bus.restore_valid), 32'd0);
  endtask

  initial begin
    bus.move_valid = 1'b0;
    bus.move_heap  = '0;
    bus.move_taken = '0;
    bus.undo_req   = 1'b0;
    for (int i = 0; i < HEAPS; i++) heaps[i] = 4'd0;

    // Reset values
    tick();
    tick();
    check("rst_restore_valid", 32'(bus.restore_valid), 32'd0);
    check("rst_restore_heap", 32'(bus.restore_heap), 32'd0);
    check("rst_restore_value", 32'(bus.restore_value), 32'd0);
    check("rst_restore_sat", 32'(bus.restore_sat), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_undo_empty", 32'(bus.undo_empty), 32'd0);
    check("rst_move_drop", 32'(bus.move_drop), 32'd0);
    check("rst_depth", 32'(bus.depth_count), 32'd0);
    check("rst_heap_sel", 32'(bus.heap_sel), 32'd0);
    reset = 1'b0;
    tick();

    // Single push/undo: 5 + 3 = 8
    heaps[2] = 4'd5;
    do_push(2'd2, 4'd3);
    do_undo(1'b0);

    // LIFO ordering, then undo on empty history
    heaps[0] = 4'd2;
    heaps[1] = 4'd6;
    heaps[3] = 4'd7;
    do_push(2'd0, 4'd1);
    do_push(2'd1, 4'd2);
    do_push(2'd3, 4'd4);
    do_undo(1'b0);
    do_undo(1'b0);
    do_undo(1'b0);
    do_undo(1'b0);

    // Overflow: ten pushes keep only the last eight
    for (int i = 0; i < HEAPS; i++) heaps[i] = 4'd1;
    for (int i = 1; i <= 10; i++) do_push(2'(i % 4), 4'(i));
    check("depth_saturated", 32'(bus.depth_count), 32'(DEPTH));
    for (int i = 0; i < 9; i++) do_undo(1'b0);

    // Saturating restore: 12 + 9 -> 15 with sat
    heaps[1] = 4'd12;
    do_push(2'd1, 4'd9);
    do_undo(1'b0);

    // Same-cycle push and undo: push wins, undo discarded silently
    heaps[3] = 4'd7;
    bus.move_valid = 1'b1;
    bus.move_heap  = 2'd3;
    bus.move_taken = 4'd2;
    bus.undo_req   = 1'b1;
    model.push_back(mv_t'{heap: 2'd3, taken: 4'd2});
    tick();
    bus.move_valid = 1'b0;
    bus.undo_req   = 1'b0;
    check("simul_depth", 32'(bus.depth_count), 32'(model.size()));
    check("simul_busy", 32'(bus.busy), 32'd0);
    check("simul_no_empty", 32'(bus.undo_empty), 32'd0);
    tick();
    check("simul_still_idle", 32'(bus.busy), 32'd0);

    // Move offered while busy is dropped
    do_undo(1'b1);

    // Reset during ADD abandons the restore
    heaps[2] = 4'd3;
    do_push(2'd2, 4'd1);
    do_push(2'd2, 4'd2);
    bus.undo_req = 1'b1;
    tick();
    bus.undo_req = 1'b0;
    check("rst_mid_pop_busy", 32'(bus.busy), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_restore_valid", 32'(bus.restore_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_depth", 32'(bus.depth_count), 32'd0);
    reset = 1'b0;
    model.delete();
    tick();
    tick();
    check("post_rst_no_restore", 32'(bus.restore_valid), 32'd0);
    do_undo(1'b0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
